guess_scorer: RTL and testbench

//  Scores one committed Mastermind guess against the stored secret code and reports

---
 rtl/guess_scorer.sv | 150 +++++++++++++++
 tb/tb_guess_scorer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/guess_scorer.sv
// Mastermind guess scorer: compares a snapshotted guess against the stored secret,
// one peg pair per clock, and tracks turns and end-of-game status.
module guess_scorer #(
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8,
  localparam int TURN_W   = $clog2(MAX_TURNS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_secret,
  input  logic [COLOR_W-1:0] secret0,
  input  logic [COLOR_W-1:0] secret1,
  input  logic [COLOR_W-1:0] secret2,
  input  logic [COLOR_W-1:0] secret3,
  input  logic               start,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess3,
  output logic               busy,
  output logic               done,
  output logic [2:0]         exact,
  output logic [2:0]         partial,
  output logic               win,
  output logic [TURN_W-1:0]  turn_count,
  output logic               game_over
);

  localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXACT,
    S_PARTIAL,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [1:0]         i, j;
  logic [3:0]         gused, sused;
  logic [COLOR_W-1:0] s_q [4];
  logic [COLOR_W-1:0] g_q [4];
  logic               exact_hit, partial_hit, last_pair;
  logic [TURN_W-1:0]  turn_inc;

  assign exact_hit   = (g_q[i] == s_q[i]);
  assign partial_hit = !gused[i] && !sused[j] && (g_q[i] == s_q[j]);
  assign last_pair   = (i == 2'd3) && (j == 2'd3);
  assign turn_inc    = turn_count + 1'b1;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !game_over && !load_secret) begin
          accept    = 1'b1;
          state_nxt = S_EXACT;
        end
      end
      S_EXACT:   if (i == 2'd3) state_nxt = S_PARTIAL;
      S_PARTIAL: if (last_pair) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // A new secret always restarts the game, whatever the scorer was doing.
    if (load_secret) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q        <= '{default: '0};
      exact      <= '0;
      partial    <= '0;
      win        <= 1'b0;
      turn_count <= '0;
      game_over  <= 1'b0;
      i          <= '0;
      j          <= '0;
      gused      <= '0;
      sused      <= '0;
    end else if (load_secret) begin
      s_q[0]     <= secret0;
      s_q[1]     <= secret1;
      s_q[2]     <= secret2;
      s_q[3]     <= secret3;
      exact      <= '0;
      partial    <= '0;
      win        <= 1'b0;
      turn_count <= '0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            exact   <= '0;
            partial <= '0;
            gused   <= '0;
            sused   <= '0;
            i       <= '0;
            j       <= '0;
          end
        end
        S_EXACT: begin
          if (exact_hit) begin
            exact    <= exact + 3'd1;
            gused[i] <= 1'b1;
            sused[i] <= 1'b1;
          end
          i <= i + 2'd1;
        end
        S_PARTIAL: begin
          if (partial_hit) begin
            partial  <= partial + 3'd1;
            gused[i] <= 1'b1;
            sused[j] <= 1'b1;
          end
          j <= j + 2'd1;
          if (j == 2'd3) i <= i + 2'd1;
          // Turn results are registered on entry to DONE so they are valid with done.
          if (last_pair) begin
            win        <= (exact == 3'd4);
            turn_count <= (turn_count == MAX_T) ? turn_count : turn_inc;
            game_over  <= (exact == 3'd4) || (turn_inc == MAX_T);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      g_q[0] <= guess0;
      g_q[1] <= guess1;
      g_q[2] <= guess2;
      g_q[3] <= guess3;
    end
  end

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: table of scoring vectors plus multi-cycle sequences.
module tb_guess_scorer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_secret;
  logic [2:0] secret0, secret1, secret2, secret3;
  logic       start;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       busy, done, win, game_over;
  logic [2:0] exact, partial;
  logic [3:0] turn_count;

  int tests  = 0;
  int failed = 0;

  guess_scorer #(.COLOR_W(3), .MAX_TURNS(8)) dut (
    .clk(clk), .reset(reset), .load_secret(load_secret),
    .secret0(secret0), .secret1(secret1), .secret2(secret2), .secret3(secret3),
    .start(start),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .busy(busy), .done(done), .exact(exact), .partial(partial), .win(win),
    .turn_count(turn_count), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][2:0] s;
    logic [3:0][2:0] g;
    int e;
    int p;
    int w;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0][2:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][2:0] r;
    r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d);
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0][2:0] s);
    secret0 = s[0]; secret1 = s[1]; secret2 = s[2]; secret3 = s[3];
    load_secret = 1'b1;
    @(posedge clk); #1;
    load_secret = 1'b0;
  endtask

  task automatic set_guess(input logic [3:0][2:0] g);
    guess0 = g[0]; guess1 = g[1]; guess2 = g[2]; guess3 = g[3];
  endtask

  // Pulse start and count edges until done is seen (-1 if never within 40).
  task automatic score(input logic [3:0][2:0] g, output int lat);
    set_guess(g);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic watch_quiet(input int cycles, output int busy_seen, output int done_seen);
    busy_seen = 0;
    done_seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
  endtask

  initial begin
    int lat, bs, ds;
    vecs[0] = '{mk(1,2,3,4), mk(1,2,3,4), 4, 0, 1};
    vecs[1] = '{mk(1,2,3,4), mk(4,3,2,1), 0, 4, 0};
    vecs[2] = '{mk(1,1,2,2), mk(1,2,1,1), 1, 2, 0};
    vecs[3] = '{mk(1,2,3,4), mk(5,5,6,6), 0, 0, 0};
    vecs[4] = '{mk(1,2,3,4), mk(1,1,1,1), 1, 0, 0};
    vecs[5] = '{mk(7,0,7,0), mk(0,7,0,7), 0, 4, 0};
    vecs[6] = '{mk(3,3,5,5), mk(3,5,3,6), 1, 2, 0};

    reset = 1'b1; load_secret = 1'b0; start = 1'b0;
    secret0 = '0; secret1 = '0; secret2 = '0; secret3 = '0;
    guess0 = '0; guess1 = '0; guess2 = '0; guess3 = '0;
    #3 reset = 1'b0;
    #14;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst exact", exact, 0);
    check("rst partial", partial, 0);
    check("rst win", win, 0);
    check("rst turn_count", turn_count, 0);
    check("rst game_over", game_over, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      load(vecs[k].s);
      score(vecs[k].g, lat);
      check($sformatf("vec%0d latency", k), lat, 20);
      check($sformatf("vec%0d exact", k), exact, vecs[k].e);
      check($sformatf("vec%0d partial", k), partial, vecs[k].p);
      check($sformatf("vec%0d win", k), win, vecs[k].w);
      check($sformatf("vec%0d turn_count", k), turn_count, 1);
      check($sformatf("vec%0d game_over", k), game_over, vecs[k].w);
      @(posedge clk); #1;
      check($sformatf("vec%0d busy after", k), busy, 0);
    end

    // Eight losing turns end the game; a ninth start is refused.
    load(mk(0,0,0,0));
    for (int k = 1; k <= 8; k++) begin
      score(mk(1,1,1,1), lat);
      check($sformatf("turn%0d latency", k), lat, 20);
      check($sformatf("turn%0d turn_count", k), turn_count, k);
      check($sformatf("turn%0d game_over", k), game_over, (k == 8) ? 1 : 0);
      @(posedge clk); #1;
    end
    set_guess(mk(0,0,0,0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("turn9 busy", busy, 0);
    watch_quiet(25, bs, ds);
    check("turn9 busy seen", bs, 0);
    check("turn9 done seen", ds, 0);
    check("turn9 turn_count", turn_count, 8);
    load(mk(0,0,0,0));
    check("reload turn_count", turn_count, 0);
    check("reload game_over", game_over, 0);

    // Start and guess changes during scoring are ignored.
    load(mk(1,2,3,4));
    set_guess(mk(4,3,2,1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        set_guess(mk(1,2,3,4));
        start = 1'b1;
      end
      if (n == 3) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("busy-start latency", lat, 20);
    check("busy-start exact", exact, 0);
    check("busy-start partial", partial, 4);
    check("busy-start turn_count", turn_count, 1);

    // load_secret during PARTIAL aborts the score.
    load(mk(1,2,3,4));
    set_guess(mk(1,2,3,4));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
    end
    check("abort busy before", busy, 1);
    load_secret = 1'b1;
    @(posedge clk); #1;
    load_secret = 1'b0;
    check("abort busy", busy, 0);
    watch_quiet(30, bs, ds);
    check("abort done seen", ds, 0);
    check("abort turn_count", turn_count, 0);
    check("abort exact", exact, 0);

    // load_secret and start together: start is dropped.
    load_secret = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    load_secret = 1'b0;
    start = 1'b0;
    watch_quiet(5, bs, ds);
    check("load+start busy seen", bs, 0);

    // Asynchronous reset in the middle of EXACT.
    score(mk(4,3,2,1), lat);
    check("pre-reset turn_count", turn_count, 1);
    @(posedge clk); #1;
    set_guess(mk(1,2,3,4));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async exact", exact, 0);
    check("async partial", partial, 0);
    check("async turn_count", turn_count, 0);
    check("async done", done, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    watch_quiet(30, bs, ds);
    check("post-reset done seen", ds, 0);
    check("post-reset busy seen", bs, 0);
    load(mk(1,2,3,4));
    score(mk(1,2,4,3), lat);
    check("post-reset latency", lat, 20);
    check("post-reset exact", exact, 2);
    check("post-reset partial", partial, 2);
    check("post-reset turn_count", turn_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
